// File: rtl/adv_cfg_sequencer_pkg.sv
// Shared ADV7513 configuration definitions: mode indices, table entry layout,
// end-of-table marker, sequencer states and the register init table contents.
package adv_cfg_sequencer_pkg;

  typedef enum logic [2:0] {
    MODE_1080P  = 3'd0,
    MODE_960P   = 3'd1,
    MODE_480P   = 3'd2,
    MODE_VGA    = 3'd3,
    MODE_240PX3 = 3'd4
  } cfg_mode_e;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;

  localparam logic [7:0] END_MARKER = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_ISSUE, ST_WAIT, ST_SETTLE, ST_FAIL
  } state_e;

  // Every mode shares the power-up block; only aspect ratio and HDMI/pixel-repeat differ.
  function automatic cfg_entry_t rom_entry(input logic [2:0] cfg, input logic [4:0] idx);
    cfg_entry_t e;
    e = '{reg_addr: END_MARKER, data: 8'h00};
    if (cfg <= MODE_240PX3) begin
      case (idx)
        5'd0:    e = '{8'h41, 8'h10};
        5'd1:    e = '{8'h98, 8'h03};
        5'd2:    e = '{8'h9A, 8'hE0};
        5'd3:    e = '{8'h9C, 8'h30};
        5'd4:    e = '{8'h17, (cfg == MODE_1080P || cfg == MODE_960P) ? 8'h02 : 8'h00};
        5'd5:    e = '{8'hAF, (cfg == MODE_240PX3) ? 8'h04 : 8'h06};
        default: e = '{reg_addr: END_MARKER, data: 8'h00};
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/adv_cfg_sequencer_if.sv
// Mode request, I2C master handshake and status bundle of the ADV7513 sequencer.
interface adv_cfg_sequencer_if;
  logic [2:0] cfg_sel;
  logic       cfg_valid;
  logic       i2c_req;
  logic [7:0] i2c_reg;
  logic [7:0] i2c_data;
  logic       i2c_ack;
  logic       i2c_done;
  logic       i2c_nack;
  logic       busy;
  logic       cfg_done;
  logic       cfg_error;
  logic [2:0] active_cfg;

  modport slave (
    input  cfg_sel, cfg_valid, i2c_ack, i2c_done, i2c_nack,
    output i2c_req, i2c_reg, i2c_data, busy, cfg_done, cfg_error, active_cfg
  );

  modport master (
    output cfg_sel, cfg_valid, i2c_ack, i2c_done, i2c_nack,
    input  i2c_req, i2c_reg, i2c_data, busy, cfg_done, cfg_error, active_cfg
  );
endinterface

// File: rtl/adv_reg_rom.sv
// 256x16 register init table, addressed {cfg[2:0], entry[4:0]}, one-cycle registered read.
module adv_reg_rom
  import adv_cfg_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic [7:0] addr,
  output cfg_entry_t q
);

  cfg_entry_t table_mem [256];
  cfg_entry_t q_reg;

  for (genvar gi = 0; gi < 256; gi++) begin : g_tbl
    assign table_mem[gi] = rom_entry(3'(gi / 32), 5'(gi % 32));
  end

  always_ff @(posedge clock) begin
    q_reg <= table_mem[addr];
  end

  assign q = q_reg;

endmodule

// File: rtl/adv_cfg_sequencer.sv
// ADV7513 mode configuration sequencer: walks the register table over I2C with retry.
// Optional ADV_HPD_GATE_EN adds an hpd input that gates start and aborts on hot-unplug.
module adv_cfg_sequencer
  import adv_cfg_sequencer_pkg::*;
#(
  parameter int MAX_RETRY     = 3,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
`ifdef ADV_HPD_GATE_EN
  input  logic hpd,
`endif
  adv_cfg_sequencer_if.slave bus
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);

  state_e             state_reg, state_next;
  logic [2:0]         cfg_reg, cfg_next;
  logic [4:0]         idx_reg, idx_next;
  logic [RETRY_W-1:0] retry_reg, retry_next;
  logic [SET_W-1:0]   settle_reg, settle_next;
  logic               pend_valid_reg, pend_valid_next;
  logic [2:0]         pend_sel_reg, pend_sel_next;
  logic               boot_reg, boot_next;
  logic [2:0]         active_reg, active_next;
  logic               done_reg, done_next;
  logic               error_reg, error_next;
  logic               hpd_ok, sel_ok, start;
  logic               i2c_req_c, busy_c;
  cfg_entry_t         rom_q;

`ifdef ADV_HPD_GATE_EN
  assign hpd_ok = hpd;
`else
  assign hpd_ok = 1'b1;
`endif

  assign sel_ok = bus.cfg_valid && (bus.cfg_sel <= MODE_240PX3);
  assign start  = (state_reg == ST_IDLE) && hpd_ok && (sel_ok || pend_valid_reg || boot_reg);

  // Address from next-state values so the entry is already valid during FETCH.
  adv_reg_rom u_rom (
    .clock (clock),
    .addr  ({cfg_next, idx_next}),
    .q     (rom_q)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cfg_reg        <= '0;
      idx_reg        <= '0;
      retry_reg      <= '0;
      settle_reg     <= '0;
      pend_valid_reg <= 1'b0;
      pend_sel_reg   <= '0;
      boot_reg       <= 1'b1;
      active_reg     <= '0;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cfg_reg        <= cfg_next;
      idx_reg        <= idx_next;
      retry_reg      <= retry_next;
      settle_reg     <= settle_next;
      pend_valid_reg <= pend_valid_next;
      pend_sel_reg   <= pend_sel_next;
      boot_reg       <= boot_next;
      active_reg     <= active_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cfg_next        = cfg_reg;
    idx_next        = idx_reg;
    retry_next      = retry_reg;
    settle_next     = settle_reg;
    pend_valid_next = pend_valid_reg;
    pend_sel_next   = pend_sel_reg;
    boot_next       = boot_reg;
    active_next     = active_reg;
    done_next       = 1'b0;
    error_next      = error_reg;

    // Any accepted request that does not start a sequence right now waits here.
    if (sel_ok && !start) begin
      pend_valid_next = 1'b1;
      pend_sel_next   = bus.cfg_sel;
    end

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          cfg_next        = sel_ok ? bus.cfg_sel : (pend_valid_reg ? pend_sel_reg : MODE_1080P);
          pend_valid_next = 1'b0;
          boot_next       = 1'b0;
          idx_next        = '0;
          retry_next      = '0;
          settle_next     = '0;
          error_next      = 1'b0;
          state_next      = ST_FETCH;
        end
      end
      ST_FETCH: state_next = (rom_q.reg_addr == END_MARKER) ? ST_SETTLE : ST_ISSUE;
      ST_ISSUE: if (bus.i2c_ack) state_next = ST_WAIT;
      ST_WAIT: begin
        if (bus.i2c_done) begin
          if (!bus.i2c_nack) begin
            retry_next = '0;
            if (idx_reg == 5'd31) begin
              state_next = ST_SETTLE;
            end else begin
              idx_next   = idx_reg + 5'd1;
              state_next = ST_FETCH;
            end
          end else if (retry_reg == RETRY_W'(MAX_RETRY - 1)) begin
            retry_next = '0;
            state_next = ST_FAIL;
          end else begin
            retry_next = retry_reg + RETRY_W'(1);
            state_next = ST_ISSUE;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_reg == SET_W'(SETTLE_CYCLES - 1)) begin
          settle_next = '0;
          done_next   = 1'b1;
          active_next = cfg_reg;
          state_next  = ST_IDLE;
        end else begin
          settle_next = settle_reg + SET_W'(1);
        end
      end
      ST_FAIL: begin
        error_next = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Hot-unplug abandons the sequence but remembers what was being applied.
    if (state_reg != ST_IDLE && !hpd_ok) begin
      state_next  = ST_IDLE;
      retry_next  = '0;
      settle_next = '0;
      done_next   = 1'b0;
      active_next = active_reg;
      error_next  = error_reg;
      if (!sel_ok && !pend_valid_reg) begin
        pend_valid_next = 1'b1;
        pend_sel_next   = cfg_reg;
      end
    end
  end

  always_comb begin
    i2c_req_c = (state_reg == ST_ISSUE);
    busy_c    = (state_reg != ST_IDLE);
  end

  assign bus.i2c_req    = i2c_req_c;
  assign bus.i2c_reg    = rom_q.reg_addr;
  assign bus.i2c_data   = rom_q.data;
  assign bus.busy       = busy_c;
  assign bus.cfg_done   = done_reg;
  assign bus.cfg_error  = error_reg;
  assign bus.active_cfg = active_reg;

endmodule

// File: tb/tb_adv_cfg_sequencer.sv
// Directed bench for adv_cfg_sequencer: an I2C responder logs every acknowledged write
// and injects NACKs on a chosen register; the main block checks logs and status.
module tb_adv_cfg_sequencer;

  logic clock;
  logic reset;
`ifdef ADV_HPD_GATE_EN
  logic hpd;
`endif

  adv_cfg_sequencer_if bus ();

  adv_cfg_sequencer #(.MAX_RETRY(3), .SETTLE_CYCLES(16)) dut (
    .clock (clock),
    .reset (reset),
`ifdef ADV_HPD_GATE_EN
    .hpd   (hpd),
`endif
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] log_mem [256];
  int          log_n = 0;
  int          done_cnt = 0;
  int          nack_given = 0;
  int          nack_limit = 0;
  logic [7:0]  nack_reg = 8'h00;
  logic [15:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // I2C master model: ack 2 cycles after the request, done 2 cycles after ack.
  initial begin
    logic [15:0] cur;
    logic        give_nack;
    bus.i2c_ack  = 1'b0;
    bus.i2c_done = 1'b0;
    bus.i2c_nack = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.i2c_req === 1'b1) begin
        repeat (2) @(negedge clock);
        cur = {bus.i2c_reg, bus.i2c_data};
        bus.i2c_ack = 1'b1;
        if (log_n < 256) log_mem[log_n] = cur;
        log_n++;
        @(negedge clock);
        bus.i2c_ack = 1'b0;
        @(negedge clock);
        give_nack = (cur[15:8] == nack_reg) && (nack_given < nack_limit);
        if (give_nack) nack_given++;
        bus.i2c_done = 1'b1;
        bus.i2c_nack = give_nack;
        @(negedge clock);
        bus.i2c_done = 1'b0;
        bus.i2c_nack = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (bus.cfg_done === 1'b1) done_cnt++;
    end
  end

  task automatic send_cfg(input logic [2:0] sel);
    @(negedge clock);
    bus.cfg_sel   = sel;
    bus.cfg_valid = 1'b1;
    @(negedge clock);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int q = 0;
    int n = 0;
    while (q < 3 && n < budget) begin
      @(negedge clock);
      n++;
      q = (bus.busy === 1'b0) ? q + 1 : 0;
    end
    check({tag, "_quiet"}, 32'(q >= 3), 32'd1);
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n = 0;
    while (bus.i2c_req !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_req_seen"}, {31'd0, bus.i2c_req}, 32'd1);
  endtask

  task automatic push_table(input int mode);
    exp_q.push_back(16'h4110);
    exp_q.push_back(16'h9803);
    exp_q.push_back(16'h9AE0);
    exp_q.push_back(16'h9C30);
    exp_q.push_back((mode == 0 || mode == 1) ? 16'h1702 : 16'h1700);
    exp_q.push_back((mode == 4) ? 16'hAF04 : 16'hAF06);
  endtask

  task automatic check_log(input string tag, input int base);
    check({tag, "_writes"}, 32'(log_n - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", tag, i), {16'd0, log_mem[base + i]}, {16'd0, exp_q[i]});
    exp_q.delete();
  endtask

  initial begin
    int base;
    int dbase;
    logic saw_busy;
    logic saw_req;

    reset         = 1'b1;
    bus.cfg_sel   = 3'd0;
    bus.cfg_valid = 1'b0;
`ifdef ADV_HPD_GATE_EN
    hpd = 1'b1;
`endif
    repeat (3) @(negedge clock);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_req", {31'd0, bus.i2c_req}, 32'd0);
    check("rst_done", {31'd0, bus.cfg_done}, 32'd0);
    check("rst_error", {31'd0, bus.cfg_error}, 32'd0);
    check("rst_active", {29'd0, bus.active_cfg}, 32'd0);

    // Reset release boots mode 0 on its own.
    base = log_n; dbase = done_cnt;
    reset = 1'b0;
    wait_quiet("boot", 1000);
    push_table(0);
    check_log("boot", base);
    check("boot_done_cnt", 32'(done_cnt - dbase), 32'd1);
    check("boot_active", {29'd0, bus.active_cfg}, 32'd0);
    check("boot_error", {31'd0, bus.cfg_error}, 32'd0);

    // Mode 2 with the third write (0x9A) NACKed twice.
    nack_reg = 8'h9A; nack_limit = nack_given + 2;
    base = log_n; dbase = done_cnt;
    send_cfg(3'd2);
    wait_quiet("retry", 1000);
    exp_q = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9AE0, 16'h9AE0, 16'h9C30, 16'h1700, 16'hAF06};
    check_log("retry", base);
    check("retry_done_cnt", 32'(done_cnt - dbase), 32'd1);
    check("retry_error", {31'd0, bus.cfg_error}, 32'd0);
    check("retry_active", {29'd0, bus.active_cfg}, 32'd2);

    // Mode 1 with the first write NACKed three times: retries exhausted.
    nack_reg = 8'h41; nack_limit = nack_given + 3;
    base = log_n; dbase = done_cnt;
    send_cfg(3'd1);
    wait_quiet("fail", 1000);
    exp_q = '{16'h4110, 16'h4110, 16'h4110};
    check_log("fail", base);
    check("fail_done_cnt", 32'(done_cnt - dbase), 32'd0);
    check("fail_error", {31'd0, bus.cfg_error}, 32'd1);
    check("fail_active", {29'd0, bus.active_cfg}, 32'd2);

    // Requests 3 then 4 arrive while mode 1 runs: only mode 4 follows.
    base = log_n; dbase = done_cnt;
    send_cfg(3'd1);
    repeat (5) @(negedge clock);
    send_cfg(3'd3);
    send_cfg(3'd4);
    wait_quiet("pend", 2000);
    push_table(1);
    push_table(4);
    check_log("pend", base);
    check("pend_done_cnt", 32'(done_cnt - dbase), 32'd2);
    check("pend_active", {29'd0, bus.active_cfg}, 32'd4);
    check("pend_error", {31'd0, bus.cfg_error}, 32'd0);

    // Out-of-range mode index is ignored.
    base = log_n;
    saw_busy = 1'b0; saw_req = 1'b0;
    send_cfg(3'd6);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      saw_busy |= (bus.busy === 1'b1);
      saw_req  |= (bus.i2c_req === 1'b1);
    end
    check("bad_sel_busy", {31'd0, saw_busy}, 32'd0);
    check("bad_sel_req", {31'd0, saw_req}, 32'd0);
    check("bad_sel_writes", 32'(log_n - base), 32'd0);

    // Reset mid-transfer drops the request and reboots mode 0.
    send_cfg(3'd3);
    wait_req("midrst", 200);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_req", {31'd0, bus.i2c_req}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_active", {29'd0, bus.active_cfg}, 32'd0);
    repeat (12) @(negedge clock);
    base = log_n; dbase = done_cnt;
    reset = 1'b0;
    wait_quiet("reboot", 1000);
    push_table(0);
    check_log("reboot", base);
    check("reboot_done_cnt", 32'(done_cnt - dbase), 32'd1);

`ifdef ADV_HPD_GATE_EN
    // Hot-unplug mid-sequence, then replug restarts mode 2 from entry 0.
    send_cfg(3'd2);
    wait_req("hpd", 200);
    hpd = 1'b0;
    @(negedge clock);
    check("hpd_req_drop", {31'd0, bus.i2c_req}, 32'd0);
    check("hpd_busy_drop", {31'd0, bus.busy}, 32'd0);
    repeat (12) @(negedge clock);
    check("hpd_held_idle", {31'd0, bus.busy}, 32'd0);
    base = log_n; dbase = done_cnt;
    hpd = 1'b1;
    wait_quiet("hpd", 1000);
    push_table(2);
    check_log("hpd", base);
    check("hpd_done_cnt", 32'(done_cnt - dbase), 32'd1);
    check("hpd_error", {31'd0, bus.cfg_error}, 32'd0);
    check("hpd_active", {29'd0, bus.active_cfg}, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
